// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-N symbol un-interleaver: pad symbol,
// pointer-width helper and lane-slice indexing.
package demux_pkg;

    // K23.7 PAD; the top level resizes it to its symbol width.
    localparam logic [7:0] PAD_SYM = 8'hF7;

    function automatic int ptr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int lane_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/demux_lane_ctr.sv
// Wrap-around lane pointer: counts 0..LANES-1 on inc, returns to 0 on clr.
module demux_lane_ctr
    import demux_pkg::*;
#(
    parameter int LANES = 4,
    parameter int PW    = ptr_width(LANES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          clr,
    output logic [PW-1:0] ptr,
    output logic          last
);

    logic [PW-1:0] ptr_next;

    assign last = (ptr == PW'(LANES - 1));

    always_comb begin
        ptr_next = ptr;
        if (clr) begin
            ptr_next = '0;
        end else if (inc) begin
            ptr_next = last ? '0 : ptr + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/demux1xn_stripe.sv
// 1-to-LANES symbol un-interleaver with registered lane-aligned output and
// partial-group flush on idle. Define DEMUX1XN_PAD_EN to pad flushed groups.
module demux1xn_stripe
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       in,
    input  logic                   valid,
    output logic [LANES*WIDTH-1:0] out,
    output logic [LANES-1:0]       valid_out
);

    localparam int PW = ptr_width(LANES);

`ifdef DEMUX1XN_PAD_EN
    localparam logic [WIDTH-1:0] FILL_SYM = WIDTH'(PAD_SYM);
    localparam logic             FILL_VLD = 1'b1;
`else
    localparam logic [WIDTH-1:0] FILL_SYM = '0;
    localparam logic             FILL_VLD = 1'b0;
`endif

    logic [PW-1:0]          ptr;
    logic                   last;
    logic                   full;
    logic                   flush;
    logic [WIDTH-1:0]       stage_reg [LANES-1];
    logic [LANES*WIDTH-1:0] out_next;
    logic [LANES-1:0]       valid_out_next;

    assign full  = valid & last;
    assign flush = ~valid & (ptr != '0);

    demux_lane_ctr #(
        .LANES (LANES),
        .PW    (PW)
    ) u_lane_ctr (
        .clk   (clk),
        .reset (reset),
        .inc   (valid),
        .clr   (~valid),
        .ptr   (ptr),
        .last  (last)
    );

    // Lane k is only written while ptr==k, which never happens on the last lane.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < LANES - 1; k++) begin
                stage_reg[k] <= '0;
            end
        end else begin
            for (int k = 0; k < LANES - 1; k++) begin
                if (valid && ptr == PW'(k)) begin
                    stage_reg[k] <= in;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES - 1; gi++) begin : g_stage_lane
            logic filled;
            assign filled = full | (PW'(gi) < ptr);
            assign out_next[lane_lsb(gi, WIDTH) +: WIDTH] = filled ? stage_reg[gi] : FILL_SYM;
            assign valid_out_next[gi] = full | (flush & (filled | FILL_VLD));
        end
    endgenerate

    // A flush never reaches the last lane, so it only ever sees live input or fill.
    assign out_next[lane_lsb(LANES - 1, WIDTH) +: WIDTH] = full ? in : FILL_SYM;
    assign valid_out_next[LANES-1] = full | (flush & FILL_VLD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out       <= '0;
            valid_out <= '0;
        end else begin
            if (full || flush) begin
                out <= out_next;
            end
            valid_out <= (full || flush) ? valid_out_next : '0;
        end
    end

endmodule

// File: doc/demux1xn_stripe.md
# demux1xn_stripe

Parametrised 1-to-N byte un-interleaver for the PCIe physical-layer datapath. It generalises the 1x2 demux to LANES lanes of WIDTH bits each. A serial stream of valid symbols is distributed round-robin across lanes and emitted as one registered, lane-aligned group. It sits between the byte-stream source and the per-lane serialisers, and adds partial-group flushing on idle.

## Interface
- `WIDTH`, default 8: bits per symbol/lane.
- `LANES`, default 4: number of output lanes, at least 2. Any value is allowed; the pointer wraps at LANES-1.
- `clk`, input, 1 bit: single clock. All state updates on the rising edge.
- `reset`, input, 1 bit: asynchronous, active-high reset.
- `in`, input, WIDTH bits: input symbol, sampled when `valid`=1.
- `valid`, input, 1 bit: input symbol qualifier.
- `out`, output, LANES*WIDTH bits: flattened lane group. Lane k occupies bits [k*WIDTH +: WIDTH], so lane 0 is in the LSBs.
- `valid_out`, output, LANES bits: per-lane valid. Bit k qualifies lane k.

## Operation
- State: lane pointer `ptr`, in range 0..LANES-1. Staging registers hold lanes 0..LANES-2.
- Edge with `valid`=1 and `ptr`<LANES-1: `in` is written to staging[ptr], then `ptr` increments.
- Edge with `valid`=1 and `ptr`=LANES-1 (full group): `out` is loaded with the staged lanes plus `in` in lane LANES-1. `valid_out` = all ones. `ptr` returns to 0.
- Edge with `valid`=0 and `ptr`≠0 (flush): the partial group is emitted.
  - Lanes 0..ptr-1 carry staged data, and their `valid_out` bits are 1.
  - The remaining lanes follow the Configuration rule.
  - `ptr` returns to 0.
- Edge with `valid`=0 and `ptr`=0: idle. `valid_out` = 0.
- `valid_out` is a one-cycle pulse. It is 0 on every edge that does not emit a group.
- `out` holds the last emitted group until the next emission.
- Reset values: `out`=0, `valid_out`=0, `ptr`=0, staging=0.
- Reset asserted mid-group: the partial group is discarded with no emission. After release, the first valid symbol goes to lane 0.
- Continuous `valid`=1 gives one full group every LANES cycles with no bubbles. The symbol on the cycle after an emission goes to lane 0.

## Timing
- Latency: the group is visible on `out`/`valid_out` one cycle after the edge that samples its last symbol.
- Flush latency: the partial group appears one cycle after the first idle (`valid`=0) edge.
- Throughput: 1 symbol per clock, with no backpressure.
- Outputs are driven from registers only, with no combinational path from `in` or `valid`.
- `ptr` width is clog2(LANES).

## Configuration
- `DEMUX1XN_PAD_EN` defined: on flush, every unfilled lane carries `PAD_SYM` (from the package) and has its `valid_out` bit set to 1. Every emission therefore has `valid_out` all ones.
- `DEMUX1XN_PAD_EN` undefined: on flush, unfilled lanes carry 0 and their `valid_out` bits are 0.
- Full-group behaviour is identical in both builds.

## Structure
- Shared package `demux_pkg` contains:
  - `PAD_SYM`, equal to 8'hF7 (K23.7 PAD), sized to WIDTH.
  - A clog2 helper for the pointer width.
  - The lane-slice index function.
- Sub-module `demux_lane_ctr`: the wrap-around lane pointer, with inputs `clk`, `reset`, `inc` and `clr`, and outputs `ptr` and `last` (`ptr`=LANES-1).
- The top level contains the staging array, the emit logic and the output registers.

## Test plan
All scenarios use LANES=4 and WIDTH=8.
- Reset release, then `in`=01,02,03,04 with `valid`=1 for 4 cycles. The next cycle gives `out`=32'h04030201 and `valid_out`=4'b1111; `valid_out`=0 on the cycle after.
- Stream 01..08 back-to-back. Two emissions appear exactly 4 cycles apart: 32'h04030201, then 32'h08070605.
- Send 0A, 0B, then `valid`=0.
  - With `DEMUX1XN_PAD_EN` undefined: the next cycle gives `out`=32'h00000B0A and `valid_out`=4'b0011.
  - With `DEMUX1XN_PAD_EN` defined: `out`=32'hF7F70B0A and `valid_out`=4'b1111.
- Send 11, 22, 33, then pulse `reset` for one cycle, then send 44..77. No emission occurs for 11–33. The next group is 32'h77665544.
- Idle for 10 cycles after reset. `valid_out` stays 0 and `out` stays 0.
- Emit 32'h04030201, then idle for 5 cycles. `out` holds 32'h04030201 and `valid_out`=0 throughout.
